// File: rtl/tt_pad_cfg_pkg.sv
// ---------------------------------------------------------------------------
// tt_pad_cfg_pkg
// Shared definitions for the pad configuration loader:
//   CFG_W_DEFAULT  default width of the pad configuration word
//   state_t        sequencer states (IDLE, GUARD_PRE, APPLY, GUARD_POST)
//   guard_cnt_w()  width of the guard down-counter for a given guard length
// ---------------------------------------------------------------------------
package tt_pad_cfg_pkg;

    localparam int CFG_W_DEFAULT = 18;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GUARD_PRE  = 2'd1,
        APPLY      = 2'd2,
        GUARD_POST = 2'd3
    } state_t;

    // The guard counter is loaded with cycles-1 and counts down to zero,
    // so it needs clog2(cycles) bits, but never fewer than one.
    function automatic int guard_cnt_w(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/tt_pad_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// tt_pad_cfg_loader_if
// Three-pin serial host link plus the readback pin.
//   sclk_in   serial clock from host (asynchronous to the system clock)
//   sdi_in    serial data, sampled on sclk rising edge
//   latch_in  apply strobe, acts on its rising edge
//   sdo       readback: MSB of the loader's shadow register
// master = host side, slave = loader side.
// ---------------------------------------------------------------------------
interface tt_pad_cfg_loader_if;

    logic sclk_in;
    logic sdi_in;
    logic latch_in;
    logic sdo;

    modport master (
        output sclk_in,
        output sdi_in,
        output latch_in,
        input  sdo
    );

    modport slave (
        input  sclk_in,
        input  sdi_in,
        input  latch_in,
        output sdo
    );

endinterface

// File: rtl/tt_sync_edge.sv
// ---------------------------------------------------------------------------
// tt_sync_edge
// Brings one asynchronous input into the clk domain through a flop chain and
// produces a one-clk-wide pulse on its rising edge.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   async_in  raw input pin
//   level     synchronized level (last stage of the chain)
//   rise      one-clk pulse when level goes 0 -> 1
// ---------------------------------------------------------------------------
module tt_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;

endmodule

// File: rtl/tt_pad_cfg_loader.sv
// ---------------------------------------------------------------------------
// tt_pad_cfg_loader
// Serial loader and sequencer for the pad configuration word. The host shifts
// a word into a shadow register over sclk/sdi; a latch with exactly CFG_W bits
// shifted runs the sequence GUARD_PRE -> APPLY -> GUARD_POST, during which the
// pad direction gate is held low and pad_config is updated only in APPLY.
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   host          serial link (sclk_in, sdi_in, latch_in in; sdo out)
//   pad_config    active configuration word to the pads
//   pad_dir_gate  1 = pad_dir may drive, 0 = pads forced to input
//   busy          high whenever the sequencer is outside IDLE
//   bit_count     bits shifted since the last latch, saturating at 31
//   err_len       sticky: the last latch saw bit_count != CFG_W
//   err_busy      sticky: an sclk or latch edge arrived while busy
// ---------------------------------------------------------------------------
module tt_pad_cfg_loader
    import tt_pad_cfg_pkg::*;
#(
    parameter int CFG_W        = CFG_W_DEFAULT,
    parameter int GUARD_CYCLES = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    tt_pad_cfg_loader_if.slave host,
    output logic [CFG_W-1:0]   pad_config,
    output logic               pad_dir_gate,
    output logic               busy,
    output logic [4:0]         bit_count,
    output logic               err_len,
    output logic               err_busy
);

    localparam int GW = guard_cnt_w(GUARD_CYCLES);

    state_t           state;
    state_t           state_next;
    logic [GW-1:0]    guard_cnt;
    logic [GW-1:0]    guard_next;
    logic [CFG_W-1:0] shadow;

    logic sclk_rise;
    logic latch_rise;
    logic sdi_sync;
    logic unused_sclk_level;
    logic unused_latch_level;
    logic unused_sdi_rise;

    tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (host.sclk_in),
        .level    (unused_sclk_level),
        .rise     (sclk_rise)
    );

    tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (host.sdi_in),
        .level    (sdi_sync),
        .rise     (unused_sdi_rise)
    );

    tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (host.latch_in),
        .level    (unused_latch_level),
        .rise     (latch_rise)
    );

    logic idle;
    logic len_ok;

    assign idle   = (state == IDLE);
    assign len_ok = (bit_count == 5'(CFG_W));

    // State and guard counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            guard_cnt <= '0;
        end else begin
            state     <= state_next;
            guard_cnt <= guard_next;
        end
    end

    // Next-state logic. Each guard phase loads GUARD_CYCLES-1 and leaves when
    // the counter reaches zero, giving exactly GUARD_CYCLES cycles per phase.
    always_comb begin
        state_next = state;
        guard_next = guard_cnt;
        case (state)
            IDLE: begin
                if (latch_rise && len_ok) begin
                    state_next = GUARD_PRE;
                    guard_next = GW'(GUARD_CYCLES - 1);
                end
            end
            GUARD_PRE: begin
                if (guard_cnt == '0) begin
                    state_next = APPLY;
                end else begin
                    guard_next = guard_cnt - 1'b1;
                end
            end
            APPLY: begin
                state_next = GUARD_POST;
                guard_next = GW'(GUARD_CYCLES - 1);
            end
            GUARD_POST: begin
                if (guard_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    guard_next = guard_cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                guard_next = '0;
            end
        endcase
    end

    // Shadow shifter, bit counter, error flags and the registered pad outputs.
    // A latch edge takes priority over a same-cycle sclk edge, which is then
    // dropped. Gate and busy are registered from the next state so that they
    // are clean flop outputs aligned exactly with the non-IDLE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow       <= '0;
            bit_count    <= '0;
            err_len      <= 1'b0;
            err_busy     <= 1'b0;
            pad_config   <= '0;
            pad_dir_gate <= 1'b1;
            busy         <= 1'b0;
        end else begin
            if (idle) begin
                if (latch_rise) begin
                    bit_count <= '0;
                    err_len   <= ~len_ok;
                    if (len_ok) begin
                        err_busy <= 1'b0;
                    end
                end else if (sclk_rise) begin
                    shadow <= {shadow[CFG_W-2:0], sdi_sync};
                    if (bit_count != 5'd31) begin
                        bit_count <= bit_count + 5'd1;
                    end
                end
            end else begin
                if (sclk_rise || latch_rise) begin
                    err_busy <= 1'b1;
                end
            end

            if (state == APPLY) begin
                pad_config <= shadow;
            end

            pad_dir_gate <= (state_next == IDLE);
            busy         <= (state_next != IDLE);
        end
    end

    assign host.sdo = shadow[CFG_W-1];

endmodule

// File: tb/tb_tt_pad_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_tt_pad_cfg_loader
// Self-checking bench for tt_pad_cfg_loader. A behavioural model tracks the
// shadow word, bit count, active configuration and error flags from the
// host-level operations (shift a bit, latch, reset); directed scenarios are
// followed by a randomized run of loads of varying length.
// ---------------------------------------------------------------------------
module tb_tt_pad_cfg_loader;

    localparam int CFG_W  = 18;
    localparam int GUARD  = 4;
    localparam int SYNC   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CFG_W-1:0] pad_config;
    logic             pad_dir_gate;
    logic             busy;
    logic [4:0]       bit_count;
    logic             err_len;
    logic             err_busy;

    tt_pad_cfg_loader_if host_if ();

    tt_pad_cfg_loader #(
        .CFG_W        (CFG_W),
        .GUARD_CYCLES (GUARD),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host         (host_if.slave),
        .pad_config   (pad_config),
        .pad_dir_gate (pad_dir_gate),
        .busy         (busy),
        .bit_count    (bit_count),
        .err_len      (err_len),
        .err_busy     (err_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of what the host should be able to observe
    logic [CFG_W-1:0] m_shadow;
    logic [CFG_W-1:0] m_pad;
    int               m_count;
    bit               m_err_len;
    bit               m_err_busy;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic modelReset();
        m_shadow   = '0;
        m_pad      = '0;
        m_count    = 0;
        m_err_len  = 1'b0;
        m_err_busy = 1'b0;
    endtask

    task automatic checkIdle(input string p);
        checkOutput({p, "_pad"},      32'(pad_config),   32'(m_pad));
        checkOutput({p, "_gate"},     32'(pad_dir_gate), 32'd1);
        checkOutput({p, "_busy"},     32'(busy),         32'd0);
        checkOutput({p, "_count"},    32'(bit_count),    32'(m_count));
        checkOutput({p, "_err_len"},  32'(err_len),      32'(m_err_len));
        checkOutput({p, "_err_busy"}, 32'(err_busy),     32'(m_err_busy));
        checkOutput({p, "_sdo"},      32'(host_if.sdo),  32'(m_shadow[CFG_W-1]));
    endtask

    // One slow serial bit: data set well before sclk rises, held well after.
    task automatic shiftBit(input bit b);
        @(negedge clk);
        checkOutput("sdo_pre_shift", 32'(host_if.sdo), 32'(m_shadow[CFG_W-1]));
        host_if.sdi_in = b;
        waitClks(3);
        host_if.sclk_in = 1'b1;
        waitClks(5);
        host_if.sclk_in = 1'b0;
        waitClks(4);
        m_shadow = {m_shadow[CFG_W-2:0], b};
        if (m_count < 31) m_count++;
    endtask

    // Shift nbits MSB-first; bits above the word width are random filler.
    task automatic applyStimulus(input logic [CFG_W-1:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (i < CFG_W) shiftBit(word[i]);
            else           shiftBit(1'($urandom_range(0, 1)));
        end
    endtask

    // Latch strobe. inject: 0 = plain, 1 = sclk edge during GUARD_PRE,
    // 2 = sclk edge in the same cycle as the latch edge.
    task automatic applyLatch(input int inject, input string tag);
        logic [CFG_W-1:0] old_pad;
        bit               ok;
        int               wait_cnt;
        int               low;
        int               low_seen;
        old_pad = m_pad;
        ok      = (m_count == CFG_W);
        @(negedge clk);
        host_if.latch_in = 1'b1;
        if (inject == 2) host_if.sclk_in = 1'b1;
        wait_cnt = 0;
        if (inject == 1) begin
            @(negedge clk);
            wait_cnt = 1;
            host_if.sclk_in = 1'b1;
        end
        if (ok) begin
            while (pad_dir_gate !== 1'b0 && wait_cnt < 12) begin
                @(negedge clk);
                wait_cnt++;
            end
            checkOutput({tag, "_gate_latency"}, 32'(wait_cnt), 32'(SYNC + 1));
            low = 0;
            while (pad_dir_gate === 1'b0 && low < 40) begin
                checkOutput({tag, "_busy_low"}, 32'(busy), 32'd1);
                if (low == GUARD)     checkOutput({tag, "_pad_in_apply"}, 32'(pad_config), 32'(old_pad));
                if (low == GUARD + 1) checkOutput({tag, "_pad_after_apply"}, 32'(pad_config), 32'(m_shadow));
                low++;
                @(negedge clk);
            end
            checkOutput({tag, "_gate_low_cycles"}, 32'(low), 32'(2 * GUARD + 1));
            m_pad      = m_shadow;
            m_err_len  = 1'b0;
            m_err_busy = (inject == 1);
        end else begin
            low_seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (pad_dir_gate !== 1'b1) low_seen++;
            end
            checkOutput({tag, "_no_gate_drop"}, 32'(low_seen), 32'd0);
            m_err_len = 1'b1;
        end
        m_count = 0;
        host_if.latch_in = 1'b0;
        host_if.sclk_in  = 1'b0;
        waitClks(6);
        checkIdle(tag);
    endtask

    task automatic resetMidPost(input logic [CFG_W-1:0] word);
        int w;
        applyStimulus(word, CFG_W);
        @(negedge clk);
        host_if.latch_in = 1'b1;
        w = 0;
        while (pad_dir_gate !== 1'b0 && w < 12) begin
            @(negedge clk);
            w++;
        end
        checkOutput("t5_gate_dropped", 32'(pad_dir_gate), 32'd0);
        waitClks(GUARD + 3);
        checkOutput("t5_pad_applied", 32'(pad_config), 32'(word));
        checkOutput("t5_in_post_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_gate", 32'(pad_dir_gate), 32'd1);
        checkOutput("t5_async_busy", 32'(busy), 32'd0);
        checkOutput("t5_async_pad", 32'(pad_config), 32'd0);
        @(negedge clk);
        host_if.latch_in = 1'b0;
        modelReset();
        checkIdle("t5_in_reset");
        rst_n = 1'b1;
        waitClks(8);
        checkIdle("t5_after_reset");
    endtask

    initial begin
        logic [CFG_W-1:0] ref_word;
        logic [CFG_W-1:0] w;
        int               nbits;
        int               inj;
        rst_n            = 1'b0;
        host_if.sclk_in  = 1'b0;
        host_if.sdi_in   = 1'b0;
        host_if.latch_in = 1'b0;
        modelReset();
        waitClks(3);
        checkIdle("reset");
        rst_n = 1'b1;
        waitClks(4);

        // Basic load of 0x2A5A5
        applyStimulus(18'h2A5A5, CFG_W);
        checkIdle("t1_shifted");
        applyLatch(0, "t1");
        checkOutput("t1_pad_value", 32'(pad_config), 32'h2A5A5);

        // Shift zeros; the old word appears on sdo MSB-first
        ref_word = 18'h2A5A5;
        for (int i = CFG_W - 1; i >= 0; i--) begin
            @(negedge clk);
            checkOutput("t3_sdo_seq", 32'(host_if.sdo), 32'(ref_word[i]));
            shiftBit(1'b0);
        end
        applyLatch(0, "t3");
        checkOutput("t3_pad_zero", 32'(pad_config), 32'd0);

        // Short word: rejected
        applyStimulus(18'($urandom), CFG_W - 1);
        applyLatch(0, "t2");

        // sclk edge during the guard window
        applyStimulus(18'($urandom), CFG_W);
        applyLatch(1, "t4");
        applyStimulus(18'($urandom), CFG_W);
        applyLatch(0, "t4_clear");

        // Reset in the middle of GUARD_POST
        resetMidPost(18'($urandom) | 18'h1);

        // Overlong word saturates the counter, then a clean load recovers
        applyStimulus(18'($urandom), 40);
        checkOutput("t6_saturated", 32'(bit_count), 32'd31);
        applyLatch(0, "t6");
        applyStimulus(18'($urandom), CFG_W);
        applyLatch(0, "t6_clean");

        // Same-cycle sclk and latch: latch wins, sclk edge dropped
        applyStimulus(18'($urandom), CFG_W);
        applyLatch(2, "t7_same_cycle");

        // Randomized loads
        for (int k = 0; k < 14; k++) begin
            w = 18'($urandom);
            case ($urandom_range(0, 5))
                0:       nbits = $urandom_range(0, 24);
                1:       nbits = CFG_W - 1;
                2:       nbits = CFG_W + 1;
                default: nbits = CFG_W;
            endcase
            applyStimulus(w, nbits);
            inj = 0;
            if ($urandom_range(0, 3) == 0) inj = 2;
            else if (nbits == CFG_W && $urandom_range(0, 3) == 0) inj = 1;
            applyLatch(inj, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
